// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Keeps the fetch PC, issues in-order word reads over a valid/ready request
// channel, buffers the in-order responses in a small FIFO and hands them to
// decode with a valid/ready handshake. Redirects flush the buffer and drop the
// responses still in flight; a bus error parks fetch until the next redirect.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode in the cycle it arrives when the buffer is empty.

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    input  logic        i_rsp_err,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_fault
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    entry_t          mem_q [FIFO_DEPTH];

    logic            rsp_accept;
    logic            rsp_keep;
    logic            req_fire;
    logic            bypass_hit;
    logic            push;
    logic            pop;
    logic [31:0]     redirect_pc;
    entry_t          rsp_entry;
    entry_t          head;

    // Handshake qualifiers, the entry a response would create and the decode-side view.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch can be inferred.
        redirect_pc = i_redirect_pc & ~32'h3;
        rsp_accept  = i_rsp_valid && (outstanding_q != '0);
        rsp_keep    = rsp_accept && !i_redirect && (drop_q == '0) && (state_q == ST_RUN);
        rsp_entry   = '{pc: rsp_pc_q, instr: (i_rsp_err ? 32'h0 : i_rsp_data), fault: i_rsp_err};
        head        = mem_q[rd_ptr_q];

        o_req_valid = (state_q == ST_RUN) && !i_redirect &&
                      (int'(outstanding_q) + int'(count_q) < FIFO_DEPTH);
        o_req_addr  = pc_q;
        req_fire    = o_req_valid && i_req_ready;

`ifdef FETCH_BYPASS_EN
        bypass_hit  = rsp_keep && (count_q == '0);
`else
        bypass_hit  = 1'b0;
`endif

        o_instr_valid = 1'b0;
        o_instr       = 32'h0;
        o_pc          = 32'h0;
        o_fault       = 1'b0;
        if (bypass_hit) begin
            o_instr_valid = 1'b1;
            o_instr       = rsp_entry.instr;
            o_pc          = rsp_entry.pc;
            o_fault       = rsp_entry.fault;
        end else if (count_q != '0) begin
            o_instr_valid = !i_redirect;
            o_instr       = head.instr;
            o_pc          = head.pc;
            o_fault       = head.fault;
        end

        pop  = !bypass_hit && o_instr_valid && i_instr_ready;
        push = rsp_keep && !(bypass_hit && i_instr_ready);
    end

    // Next-state: redirect wins over everything, otherwise issue/response/pop bookkeeping.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        count_d       = count_q;
        drop_d        = drop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (i_redirect) begin
            state_d       = ST_RUN;
            pc_d          = redirect_pc;
            rsp_pc_d      = redirect_pc;
            outstanding_d = outstanding_q - CW'(rsp_accept);
            drop_d        = outstanding_q - CW'(rsp_accept);
            count_d       = '0;
            rd_ptr_d      = wr_ptr_q;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN:  if (rsp_keep && i_rsp_err) state_d = ST_HALT;
                default: state_d = state_q;
            endcase

            if (req_fire) pc_d = pc_q + 32'd4;
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_accept);

            // Responses belonging to a flushed stream are swallowed first.
            if (rsp_accept && (drop_q != '0)) drop_d = drop_q - CW'(1);
            if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;

            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            count_q       <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Instruction buffer storage.
    // NOTE: the storage array is not reset; count_q alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= rsp_entry;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit.
// The memory is a queue of accepted requests; decode output is compared
// against the stream of consecutive PCs starting at the last redirect target.

module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;
`ifdef FETCH_BYPASS_EN
    localparam logic        BYP = 1'b1;
`else
    localparam logic        BYP = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_req_valid;
    logic        i_req_ready = 1'b0;
    logic [31:0] o_req_addr;
    logic        i_rsp_valid = 1'b0;
    logic [31:0] i_rsp_data = 32'h0;
    logic        i_rsp_err = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_fault;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_req_valid   (o_req_valid),
        .i_req_ready   (i_req_ready),
        .o_req_addr    (o_req_addr),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_data    (i_rsp_data),
        .i_rsp_err     (i_rsp_err),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_fault       (o_fault)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } pend_t;

    pend_t       pend_q[$];
    int          checks = 0;
    int          errors = 0;

    // stimulus controls: 0 = low, 1 = high, 2 = random
    int          ready_mode = 0;
    int          instr_mode = 0;
    int          rsp_mode   = 0;
    logic        redir_cmd  = 1'b0;
    logic [31:0] redir_tgt  = 32'h0;

    // reference model state
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    logic        halted;
    logic        err_seen;
    int          epoch = 0;
    int          n_req = 0;
    int          n_pop = 0;
    logic        got_first_pop, got_first_req, seen_zero_req;
    logic [31:0] first_pop_pc, first_req_addr, last_fault_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a == 32'h0000_0300) || (a[31:16] == 16'hBAD0 && a[5:2] == 4'd7);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic model_reset();
        exp_req = RST_PC;
        exp_pc = RST_PC;
        halted = 1'b0;
        err_seen = 1'b0;
        got_first_pop = 1'b0;
        got_first_req = 1'b0;
        pend_q.delete();
        epoch++;
    endtask

    // One clock cycle: drive at the falling edge, evaluate 1 ns later.
    task automatic cycle();
        pend_t r;
        logic [31:0] tgt;
        @(negedge i_clk);
        i_redirect    = redir_cmd;
        i_redirect_pc = redir_tgt;
        redir_cmd     = 1'b0;
        i_req_ready   = pick(ready_mode);
        i_instr_ready = pick(instr_mode);
        if (pend_q.size() > 0 && pick(rsp_mode)) begin
            i_rsp_valid = 1'b1;
            i_rsp_data  = mem_data(pend_q[0].addr);
            i_rsp_err   = mem_err(pend_q[0].addr);
        end else begin
            i_rsp_valid = 1'b0;
            i_rsp_data  = $urandom;
            i_rsp_err   = 1'b0;
        end
        #1;
        if (i_redirect) begin
            check("redir_req_valid", o_req_valid, 1'b0);
            check("redir_instr_valid", o_instr_valid, 1'b0);
            tgt = {i_redirect_pc[31:2], 2'b00};
            exp_req = tgt;
            exp_pc = tgt;
            halted = 1'b0;
            err_seen = 1'b0;
            got_first_pop = 1'b0;
            got_first_req = 1'b0;
            epoch++;
            if (i_rsp_valid) r = pend_q.pop_front();
        end else begin
            if (err_seen) check("halt_no_req", o_req_valid, 1'b0);
            if (o_instr_valid && i_instr_ready) begin
                check("pop_after_fault", halted, 1'b0);
                check("o_pc", o_pc, exp_pc);
                check("o_fault", o_fault, mem_err(exp_pc));
                check("o_instr", o_instr, mem_err(exp_pc) ? 32'h0 : mem_data(exp_pc));
                if (!got_first_pop) begin
                    got_first_pop = 1'b1;
                    first_pop_pc = o_pc;
                end
                if (o_fault) last_fault_pc = o_pc;
                if (mem_err(exp_pc)) halted = 1'b1;
                exp_pc += 32'd4;
                n_pop++;
            end
            if (i_rsp_valid) begin
                r = pend_q.pop_front();
                if (r.epoch == epoch && mem_err(r.addr)) err_seen = 1'b1;
            end
            if (o_req_valid && i_req_ready) begin
                check("req_addr", o_req_addr, exp_req);
                if (!got_first_req) begin
                    got_first_req = 1'b1;
                    first_req_addr = o_req_addr;
                end
                if (o_req_addr == 32'h0) seen_zero_req = 1'b1;
                pend_q.push_back('{addr: o_req_addr, epoch: epoch});
                exp_req += 32'd4;
                n_req++;
            end
        end
        check("credit", 32'(pend_q.size() <= DEPTH), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redir_cmd = 1'b1;
        redir_tgt = tgt;
        cycle();
    endtask

    // Let stale responses come back without issuing anything new.
    task automatic drain();
        ready_mode = 0;
        rsp_mode = 1;
        instr_mode = 1;
        run(6);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b0;
        i_redirect = 1'b0;
        i_instr_ready = 1'b0;
        #1;
        check("rst_req_valid", o_req_valid, 1'b0);
        check("rst_instr_valid", o_instr_valid, 1'b0);
        check("rst_req_addr", o_req_addr, RST_PC);
        check("rst_instr", o_instr, 32'h0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_fault", o_fault, 1'b0);
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("idle_req_valid", o_req_valid, 1'b0);
    endtask

    initial begin
        int base;

        // reset and steady streaming from RESET_PC
        ready_mode = 1;
        instr_mode = 1;
        rsp_mode = 1;
        do_reset();
        cycle();
        check("first_req_cycle", o_req_valid, 1'b1);
        base = n_pop;
        run(20);
        check("steady_pops", 32'(n_pop - base >= 12), 32'd1);

        // decode stall: issue must stop at the credit limit
        instr_mode = 0;
        base = n_req;
        run(10);
        check("stall_req_cnt", 32'(n_req - base <= DEPTH), 32'd1);
        check("stall_req_valid", o_req_valid, 1'b0);
        instr_mode = 1;
        base = n_pop;
        run(10);
        check("stall_release_pops", 32'(n_pop - base >= 3), 32'd1);

        // redirect with two requests in flight: both responses dropped
        drain();
        ready_mode = 1;
        rsp_mode = 0;
        redirect_to(32'h0000_0200);
        run(3);
        check("two_outstanding", 32'(pend_q.size()), 32'd2);
        check("blocked_req_valid", o_req_valid, 1'b0);
        redirect_to(32'h0000_0403);
        rsp_mode = 1;
        run(10);
        check("redir_first_req", first_req_addr, 32'h0000_0400);
        check("redir_first_pop", first_pop_pc, 32'h0000_0400);

        // redirect coinciding with a response
        drain();
        ready_mode = 1;
        rsp_mode = 0;
        redirect_to(32'h0000_0600);
        run(3);
        rsp_mode = 1;
        redirect_to(32'h0000_0700);
        run(10);
        check("redir_rsp_first_pop", first_pop_pc, 32'h0000_0700);

        // bus error at 0x300 halts fetch until redirect
        drain();
        ready_mode = 1;
        last_fault_pc = 32'h0;
        redirect_to(32'h0000_02F8);
        run(15);
        check("fault_pc", last_fault_pc, 32'h0000_0300);
        check("halt_req_valid", o_req_valid, 1'b0);
        redirect_to(32'h0000_0500);
        run(10);
        check("resume_first_pop", first_pop_pc, 32'h0000_0500);

        // PC wrap at the top of the address space
        drain();
        ready_mode = 1;
        seen_zero_req = 1'b0;
        redirect_to(32'hFFFF_FFF4);
        run(10);
        check("wrap_req_zero", seen_zero_req, 1'b1);

        // response-to-decode latency with an empty buffer
        drain();
        ready_mode = 1;
        rsp_mode = 0;
        redirect_to(32'h0000_0800);
        cycle();
        ready_mode = 0;
        instr_mode = 0;
        cycle();
        rsp_mode = 1;
        cycle();
        check("lat_same_cycle", o_instr_valid, BYP);
        rsp_mode = 0;
        cycle();
        check("lat_next_cycle", o_instr_valid, 1'b1);
        check("lat_pc", o_pc, 32'h0000_0800);
        instr_mode = 1;
        run(3);

        // reset in the middle of buffered traffic
        ready_mode = 1;
        rsp_mode = 1;
        instr_mode = 0;
        run(6);
        instr_mode = 1;
        do_reset();
        cycle();
        check("rerst_req_valid", o_req_valid, 1'b1);

        // randomized traffic with random redirects
        ready_mode = 2;
        instr_mode = 2;
        rsp_mode = 2;
        base = n_pop;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                redir_cmd = 1'b1;
                case ($urandom_range(0, 3))
                    0:       redir_tgt = {16'h0000, 16'($urandom)};
                    1:       redir_tgt = {16'hBAD0, 16'($urandom)};
                    2:       redir_tgt = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
                    default: redir_tgt = $urandom;
                endcase
            end
            cycle();
        end
        check("random_progress", 32'(n_pop - base > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that produces the instruction word and PC consumed by the decode stage.
- Holds the fetch PC and issues in-order word reads to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports redirect (branch/jump/trap) flushes and memory error faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2; also the cap on (outstanding requests + buffered entries).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- o_req_valid  output  1  fetch request valid.
- i_req_ready  input  1  memory accepts request.
- o_req_addr  output  32  word-aligned fetch address.
- i_rsp_valid  input  1  response valid; responses return in request order, one per accepted request.
- i_rsp_data  input  32  instruction word.
- i_rsp_err  input  1  bus error for this response.
- i_redirect  input  1  flush and restart fetch.
- i_redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- o_instr_valid  output  1  buffered instruction available to decode.
- i_instr_ready  input  1  decode accepts instruction.
- o_instr  output  32  instruction word.
- o_pc  output  32  PC of o_instr.
- o_fault  output  1  entry is a fetch fault; o_instr = 0.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, fetch PC = RESET_PC, FIFO empty, outstanding = 0, drop = 0.
  - o_req_valid = 0, o_instr_valid = 0, o_req_addr = RESET_PC, o_instr/o_pc/o_fault = 0.
- States:
  - IDLE → RUN unconditionally on the first clock after reset release.
  - RUN → HALT when a response with i_rsp_err = 1 and drop = 0 is written to the FIFO.
  - HALT → RUN only on i_redirect.
  - i_redirect in RUN stays in RUN. i_redirect in IDLE loads the PC and goes to RUN.
- Request issue:
  - o_req_valid = (state == RUN) && !i_redirect && (outstanding + fifo_count < FIFO_DEPTH).
  - o_req_addr = fetch PC.
  - On o_req_valid && i_req_ready: PC += 4 (32-bit wrap, 32'hFFFF_FFFC → 0), outstanding++.
  - o_req_addr is held stable while o_req_valid = 1 and i_req_ready = 0.
- Response:
  - Each i_rsp_valid decrements outstanding.
  - If drop > 0: discard the response and decrement drop.
  - Otherwise write {pc, data, err} to the FIFO, where pc is that request's address. Track it with a response PC counter, advanced by 4 per non-dropped response.
  - Error entries store instr = 0 and fault = 1.
  - Responses arriving in HALT with drop = 0 are discarded.
- Credit rule: outstanding + fifo_count ≤ FIFO_DEPTH at all times, so the FIFO never overflows. A response with outstanding = 0 is a protocol error and is ignored.
- Decode side:
  - o_instr_valid = FIFO non-empty && !i_redirect.
  - Pop on o_instr_valid && i_instr_ready.
  - Simultaneous push and pop is allowed when the FIFO is full.
  - Latency: a response is visible on o_instr_valid the cycle after i_rsp_valid.
  - Minimum reset-to-first-request: o_req_valid is high in the 2nd cycle after reset release.
- Redirect (i_redirect = 1, highest priority):
  - Next cycle: FIFO empty.
  - Fetch PC and response PC = {i_redirect_pc[31:2], 2'b00}.
  - drop = outstanding − (i_rsp_valid ? 1 : 0).
  - A response in the redirect cycle is discarded. No request issues and no decode pop occurs in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop is recomputed each time.
- Reset mid-operation: all state cleared immediately; in-flight memory responses are the memory's concern (memory is reset together).

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, drop = 0, state is RUN and no redirect, a valid non-dropped response is presented combinationally on o_instr/o_pc/o_fault with o_instr_valid = 1 in the same cycle. If i_instr_ready = 1, it is consumed without a FIFO write. If not, it is written to the FIFO as normal. Zero-cycle response-to-decode latency.
- Undefined: always one cycle, through the FIFO.

Test Plan:
- Reset with RESET_PC = 32'h0000_0100, i_req_ready = 1, memory latency 1, i_instr_ready = 1 → request addresses 0x100, 0x104, 0x108… and o_pc sequence 0x100, 0x104… with matching words, one per cycle in steady state.
- i_instr_ready = 0 for 10 cycles → at most FIFO_DEPTH (2) requests outstanding or buffered and o_req_valid = 0 thereafter. Release → no word lost or duplicated.
- Two requests outstanding (0x200, 0x204), i_redirect with i_redirect_pc = 32'h0000_0403 → both responses dropped, next request 0x400, next o_pc 0x400.
- Redirect in the same cycle as a response → that response discarded, drop = outstanding − 1, the following valid output has o_pc = redirect PC.
- Response to 0x300 with i_rsp_err = 1 → o_fault = 1, o_instr = 0, o_pc = 0x300, o_req_valid stays 0 until i_redirect to 0x500 → fetch resumes at 0x500.
- Fetch PC 32'hFFFF_FFFC → next request address 32'h0000_0000. With FETCH_BYPASS_EN and an empty FIFO: o_instr_valid is asserted in the same cycle as i_rsp_valid.
